// File: rtl/corescore_emitter_uart_pkg.sv
// corescore_emitter_uart_pkg
//   Frame-format constants and the frame builder shared by the UART emitter.
//   An 8N1 frame is ten bits on the wire: start (0), eight data bits LSB
//   first, stop (1).
package corescore_emitter_uart_pkg;

  localparam int FRAME_BITS = 10;

  // Wire-order frame image. Bit 0 goes out first, so the word is shifted
  // right and its LSB drives the line.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/corescore_emitter_uart.sv
// corescore_emitter_uart
//   Transmit-only 8N1 UART. One byte is accepted when i_valid and o_ready are
//   both high on a rising clk edge; the frame starts on the very next cycle
//   and lasts exactly 10*DIV cycles, DIV = clk_freq_hz / baud_rate.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high; aborts any frame in flight
//   i_data     byte to send, latched on acceptance only
//   i_valid    send request; ignored while busy (no queuing)
//   o_ready    registered; high when idle. !o_ready is the busy flag
//   o_uart_tx  registered serial line, idle high
module corescore_emitter_uart
  import corescore_emitter_uart_pkg::*;
#(
  parameter int clk_freq_hz = 100000000,
  parameter int baud_rate   = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_uart_tx
);

  localparam int DIV       = clk_freq_hz / baud_rate;
  localparam int FRAME_LEN = FRAME_BITS * DIV;
  localparam int CNT_W     = (DIV < 2) ? 1 : $clog2(DIV);

  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(DIV - 1);
  localparam logic [3:0]       LAST_BIT    = 4'(FRAME_BITS - 1);

  // A one-cycle bit period cannot hold the counter scheme together.
  if (DIV < 2) begin : g_div_check
    $error("corescore_emitter_uart: DIV=%0d (frame %0d cycles) must be >= 2",
           DIV, FRAME_LEN);
  end

  logic [CNT_W-1:0]      baud_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_uart_tx <= 1'b1;
      o_ready   <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '1;
    end else if (o_ready) begin
      if (i_valid) begin
        shreg     <= frame_word(i_data);
        o_uart_tx <= 1'b0;            // start bit on the next cycle, no gap
        o_ready   <= 1'b0;
        baud_cnt  <= BAUD_RELOAD;
        bit_cnt   <= '0;
      end
    end else if (baud_cnt != '0) begin
      baud_cnt  <= baud_cnt - 1'b1;
      o_uart_tx <= shreg[0];          // hold current bit
    end else begin
      // Bit boundary: shift ones in from the top so the word drains to idle.
      baud_cnt <= BAUD_RELOAD;
      shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
      if (bit_cnt == LAST_BIT) begin
        // End of stop bit: line stays high, ready again on this edge.
        o_ready   <= 1'b1;
        o_uart_tx <= 1'b1;
        bit_cnt   <= '0;
      end else begin
        o_uart_tx <= shreg[1];
        bit_cnt   <= bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_corescore_emitter_uart.sv
// tb_corescore_emitter_uart
//   Three emitters share one stimulus stream: defaults (DIV=100),
//   12 MHz / 115200 (DIV=104) and a fast DIV=5 copy used for the long random
//   run. A frame-position model predicts tx/ready every cycle, a mid-bit
//   sampling receiver decodes each line, and literal expectations pin the
//   directed scenarios.
module tb_corescore_emitter_uart;

  localparam int N = 3;
  int divs [N] = '{100, 104, 5};

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     i_data = 8'h00;
  logic           i_valid = 1'b0;
  logic [N-1:0]   tx, rdy;

  corescore_emitter_uart u_def (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy[0]), .o_uart_tx(tx[0]));

  corescore_emitter_uart #(.clk_freq_hz(12000000), .baud_rate(115200)) u_104 (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy[1]), .o_uart_tx(tx[1]));

  corescore_emitter_uart #(.clk_freq_hz(1000000), .baud_rate(200000)) u_fast (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy[2]), .o_uart_tx(tx[2]));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Per emitter: busy flag, edges elapsed since acceptance, byte in flight.
  bit       m_busy  [N];
  int       m_pos   [N];
  logic [7:0] m_cur [N];
  int       m_acc   [N];
  int       m_abort [N];
  int       epoch = 0;

  always @(posedge clk) begin
    if (reset) begin
      epoch++;
      for (int k = 0; k < N; k++) begin
        if (m_busy[k]) m_abort[k]++;
        m_busy[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy[k]) begin
          if (i_valid) begin
            m_busy[k] = 1'b1;
            m_pos[k]  = 0;
            m_cur[k]  = i_data;
            m_acc[k]++;
          end
        end else begin
          m_pos[k]++;
          if (m_pos[k] == 10 * divs[k]) m_busy[k] = 1'b0;
        end
      end
    end
  end

  // Line level from frame position: bit slot = pos / DIV.
  function automatic logic exp_tx(input int k);
    int j;
    if (!m_busy[k]) return 1'b1;
    j = m_pos[k] / divs[k];
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return m_cur[k][j-1];
  endfunction

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("tx%0d", k), {31'd0, tx[k]}, {31'd0, exp_tx(k)});
        chk($sformatf("ready%0d", k), {31'd0, rdy[k]}, {31'd0, !m_busy[k]});
      end
    end
  end

  // ---------------- mid-bit sampling receiver ----------------
  int         r_pos   [N];
  int         r_epoch [N];
  int         r_cnt   [N];
  logic [7:0] r_byte  [N];
  logic [7:0] r_last  [N];
  logic [7:0] r_prev  [N];

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < N; k++) begin
        int j;
        if (r_epoch[k] != epoch) begin
          r_epoch[k] = epoch;
          r_pos[k] = -1;
        end
        if (r_pos[k] < 0) begin
          if (tx[k] == 1'b0) r_pos[k] = 0;
        end else begin
          r_pos[k]++;
        end
        if (r_pos[k] >= 0 && (r_pos[k] % divs[k]) == divs[k] / 2) begin
          j = r_pos[k] / divs[k];
          if (j == 0) chk($sformatf("rx_start%0d", k), {31'd0, tx[k]}, 32'd0);
          else if (j <= 8) r_byte[k][j-1] = tx[k];
          else begin
            chk($sformatf("rx_stop%0d", k), {31'd0, tx[k]}, 32'd1);
            chk($sformatf("rx_byte%0d", k), {24'd0, r_byte[k]}, {24'd0, m_cur[k]});
            r_prev[k] = r_last[k];
            r_last[k] = r_byte[k];
            r_cnt[k]++;
            r_pos[k] = -1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((m_busy[0] || m_busy[1] || m_busy[2]) && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", {31'd0, (m_busy[0] || m_busy[1] || m_busy[2])}, 32'd0);
    step(2);
  endtask

  // One-cycle request; returns at the negedge right after the accept edge.
  task automatic pulse(input logic [7:0] d);
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, b2, rb, i;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("reset_tx", {31'd0, tx[k]}, 32'd1);
      chk("reset_ready", {31'd0, rdy[k]}, 32'd1);
    end
    chk_on = 1'b1;
    step(2);

    // 0x61 single frame; start-bit widths 100 and 104
    pulse(8'h61);
    fork
      begin
        chk("s1_tx_c1", {31'd0, tx[0]}, 32'd0);
        step(99);  chk("s1_tx_c100", {31'd0, tx[0]}, 32'd0);
        step(1);   chk("s1_bit0", {31'd0, tx[0]}, 32'd1);
        step(100); chk("s1_bit1", {31'd0, tx[0]}, 32'd0);
        step(799); chk("s1_ready_c1000", {31'd0, rdy[0]}, 32'd0);
                   chk("s1_stop", {31'd0, tx[0]}, 32'd1);
        step(1);   chk("s1_ready_after", {31'd0, rdy[0]}, 32'd1);
                   chk("s1_idle_tx", {31'd0, tx[0]}, 32'd1);
      end
      begin
        int n;
        n = 0;
        while (tx[0] == 1'b0 && n < 400) begin n++; @(negedge clk); end
        chk("start_len_100", n, 32'd100);
      end
      begin
        int n;
        n = 0;
        while (tx[1] == 1'b0 && n < 400) begin n++; @(negedge clk); end
        chk("start_len_104", n, 32'd104);
      end
    join
    wait_idle();
    chk("s1_rx0", {24'd0, r_last[0]}, 32'h61);
    chk("s1_rx1", {24'd0, r_last[1]}, 32'h61);

    // back-to-back 0x0D, 0x0A with i_valid held
    b0 = m_acc[0]; b1 = m_acc[1];
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'h0D;
    @(posedge clk);
    @(negedge clk);
    i_data = 8'h0A;
    step(1000); chk("b2b_gap_tx", {31'd0, tx[0]}, 32'd1);
                chk("b2b_gap_ready", {31'd0, rdy[0]}, 32'd1);
    step(1);    chk("b2b_start2", {31'd0, tx[0]}, 32'd0);
                chk("b2b_busy2", {31'd0, rdy[0]}, 32'd0);
    i = 0;
    while ((m_acc[0] - b0 < 2 || m_acc[1] - b1 < 2) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    i_valid = 1'b0;
    chk("b2b_timeout", {31'd0, (i >= 3000)}, 32'd0);
    wait_idle();
    chk("b2b_first", {24'd0, r_prev[0]}, 32'h0D);
    chk("b2b_second", {24'd0, r_last[0]}, 32'h0A);
    chk("b2b_second_104", {24'd0, r_last[1]}, 32'h0A);

    // request while busy is dropped
    rb = r_cnt[0];
    pulse(8'h33);
    step(400);
    pulse(8'hFF);
    wait_idle();
    chk("busy_ignore_cnt", r_cnt[0] - rb, 32'd1);
    chk("busy_ignore_byte", {24'd0, r_last[0]}, 32'h33);

    // reset at cycle 350 of a frame, together with a request
    rb = r_cnt[0];
    pulse(8'h5A);
    step(349);
    reset   = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    i_valid = 1'b0;
    chk("abort_tx", {31'd0, tx[0]}, 32'd1);
    chk("abort_ready", {31'd0, rdy[0]}, 32'd1);
    step(1);
    chk("rst_wins_ready", {31'd0, rdy[0]}, 32'd1);
    pulse(8'h55);
    wait_idle();
    chk("after_abort_cnt", r_cnt[0] - rb, 32'd1);
    chk("after_abort_byte", {24'd0, r_last[0]}, 32'h55);

    // random run: 256 bytes through the DIV=5 emitter
    b2 = m_acc[2];
    i = 0;
    while (m_acc[2] - b2 < 256 && i < 40000) begin
      @(negedge clk);
      i_valid = 1'($urandom_range(0, 1));
      i_data  = 8'($urandom);
      i++;
    end
    @(negedge clk);
    i_valid = 1'b0;
    chk("rand_count", m_acc[2] - b2, 32'd256);
    wait_idle();
    for (int k = 0; k < N; k++)
      chk($sformatf("frames%0d", k), r_cnt[k], m_acc[k] - m_abort[k]);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
